// File: rtl/nibble_tx_ctrl.sv
// Sequencer for a 4-bit parallel-load shift register: loads a nibble, clocks it
// out MSB-first, samples Q3 once per bit period and checks it against a shadow copy.
module nibble_tx_ctrl #(
   parameter int unsigned BIT_DIV = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] DIN,
   input  logic       DIN_VALID,
   output logic       DIN_READY,
   output logic       D0,
   output logic       D1,
   output logic       D2,
   output logic       D3,
   output logic       LOAD,
   output logic       SHIFT,
   input  logic       Q3,
   output logic       TX_BIT,
   output logic       TX_STROBE,
   output logic       FRAME_DONE,
   output logic       MISMATCH,
   output logic       BUSY
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_SHIFT_HI
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);

   state_t     state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [1:0] bitcnt_q, bitcnt_d;
   logic [3:0] shadow_q, shadow_d;
   logic [3:0] dout_q, dout_d;
   logic       load_q, load_d;
   logic       shift_q, shift_d;
   logic       tx_bit_q, tx_bit_d;
   logic       tx_strobe_q, tx_strobe_d;
   logic       frame_done_q, frame_done_d;
   logic       mismatch_q, mismatch_d;
   logic       busy_q, busy_d;
   logic       ready_q, ready_d;

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      bitcnt_d     = bitcnt_q;
      shadow_d     = shadow_q;
      dout_d       = dout_q;
      tx_bit_d     = tx_bit_q;
      tx_strobe_d  = 1'b0;
      frame_done_d = 1'b0;
      mismatch_d   = mismatch_q;

      unique case (state_q)
         S_IDLE: begin
            if (DIN_VALID) begin
               shadow_d   = DIN;
               dout_d     = DIN;
               mismatch_d = 1'b0;
               bitcnt_d   = 2'd0;
               div_d      = 8'd0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            div_d   = 8'd0;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (div_q == DIV_LAST) begin
               // Q3 has settled for a full half period since the last shift edge
               div_d       = 8'd0;
               tx_bit_d    = Q3;
               tx_strobe_d = 1'b1;
               if (Q3 != shadow_q[2'd3 - bitcnt_q]) begin
                  mismatch_d = 1'b1;
               end
               if (bitcnt_q == 2'd3) begin
                  frame_done_d = 1'b1;
                  state_d      = S_IDLE;
               end else begin
                  state_d = S_SHIFT_HI;
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         S_SHIFT_HI: begin
            if (div_q == DIV_LAST) begin
               div_d    = 8'd0;
               bitcnt_d = bitcnt_q + 2'd1;
               state_d  = S_HOLD;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Strobes decoded from the next state so they come straight off flops
      load_d  = (state_d == S_LOAD);
      shift_d = (state_d == S_SHIFT_HI);
      busy_d  = (state_d != S_IDLE);
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= S_IDLE;
         div_q        <= 8'd0;
         bitcnt_q     <= 2'd0;
         shadow_q     <= 4'd0;
         dout_q       <= 4'd0;
         load_q       <= 1'b0;
         shift_q      <= 1'b0;
         tx_bit_q     <= 1'b0;
         tx_strobe_q  <= 1'b0;
         frame_done_q <= 1'b0;
         mismatch_q   <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         bitcnt_q     <= bitcnt_d;
         shadow_q     <= shadow_d;
         dout_q       <= dout_d;
         load_q       <= load_d;
         shift_q      <= shift_d;
         tx_bit_q     <= tx_bit_d;
         tx_strobe_q  <= tx_strobe_d;
         frame_done_q <= frame_done_d;
         mismatch_q   <= mismatch_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
      end
   end

   assign DIN_READY  = ready_q;
   assign D0         = dout_q[0];
   assign D1         = dout_q[1];
   assign D2         = dout_q[2];
   assign D3         = dout_q[3];
   assign LOAD       = load_q;
   assign SHIFT      = shift_q;
   assign TX_BIT     = tx_bit_q;
   assign TX_STROBE  = tx_strobe_q;
   assign FRAME_DONE = frame_done_q;
   assign MISMATCH   = mismatch_q;
   assign BUSY       = busy_q;

endmodule

// File: tb/tb_nibble_tx_ctrl.sv
// Bench for nibble_tx_ctrl at BIT_DIV=2 and BIT_DIV=1, each driving a behavioural
// shift register; expected bits are queued on accept and compared on TX_STROBE.
module tb_nibble_tx_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   logic [1:0] rst_n, din_valid, din_ready, d0, d1, d2, d3, load, shift, q3;
   logic [1:0] tx_bit, tx_strobe, frame_done, mismatch, busy, stuck, done;
   logic [3:0] din [2];

   typedef struct {
      logic b;
      logic last;
      logic mis;
   } exp_t;

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int BD = (gi == 0) ? 2 : 1;
      localparam int F  = 2 + 7 * BD;
      localparam string PFX = (gi == 0) ? "bd2_" : "bd1_";

      nibble_tx_ctrl #(.BIT_DIV(BD)) u_dut (
         .CLK       (clk),
         .RST_N     (rst_n[gi]),
         .DIN       (din[gi]),
         .DIN_VALID (din_valid[gi]),
         .DIN_READY (din_ready[gi]),
         .D0        (d0[gi]),
         .D1        (d1[gi]),
         .D2        (d2[gi]),
         .D3        (d3[gi]),
         .LOAD      (load[gi]),
         .SHIFT     (shift[gi]),
         .Q3        (q3[gi]),
         .TX_BIT    (tx_bit[gi]),
         .TX_STROBE (tx_strobe[gi]),
         .FRAME_DONE(frame_done[gi]),
         .MISMATCH  (mismatch[gi]),
         .BUSY      (busy[gi])
      );

      // External shift register: async parallel load, shifts toward Q3 on SHIFT rise
      logic [3:0] sr;
      always @(posedge shift[gi] or posedge load[gi]) begin
         if (load[gi]) sr <= {d3[gi], d2[gi], d1[gi], d0[gi]};
         else          sr <= {sr[2:0], 1'b0};
      end
      assign q3[gi] = stuck[gi] ? 1'b1 : sr[3];

      exp_t q[$];
      int   acc = 0;
      bit   active = 0;
      logic [3:0] last_nib = 4'd0;

      always @(negedge clk) begin
         int   off;
         bit   es, esh, eb, el, efd;
         exp_t e;
         if (!rst_n[gi]) begin
            q.delete();
            active   = 0;
            last_nib = 4'd0;
         end else begin
            off = cyc - acc;
            es  = 0;
            esh = 0;
            for (int k = 0; k < 4; k++) begin
               if (active && off == 2 + (2 * k + 1) * BD) es = 1;
               if (active && k < 3 && off >= 2 + (2 * k + 1) * BD && off < 2 + (2 * k + 2) * BD) esh = 1;
            end
            eb  = active && off >= 1 && off <= F - 1;
            el  = active && off == 1;
            efd = active && off == F;
            check({PFX, "load"}, 32'(load[gi]), 32'(el));
            check({PFX, "shift"}, 32'(shift[gi]), 32'(esh));
            check({PFX, "busy"}, 32'(busy[gi]), 32'(eb));
            check({PFX, "ready"}, 32'(din_ready[gi]), 32'(!eb));
            check({PFX, "strobe"}, 32'(tx_strobe[gi]), 32'(es));
            check({PFX, "frame_done"}, 32'(frame_done[gi]), 32'(efd));
            check({PFX, "dout"}, 32'({d3[gi], d2[gi], d1[gi], d0[gi]}), 32'(last_nib));
            if (el) check({PFX, "mis_clear"}, 32'(mismatch[gi]), 32'd0);
            if (es) begin
               if (q.size() == 0) begin
                  check({PFX, "q_underflow"}, 32'd0, 32'd1);
               end else begin
                  e = q.pop_front();
                  check({PFX, "tx_bit"}, 32'(tx_bit[gi]), 32'(e.b));
                  if (e.last) check({PFX, "mismatch"}, 32'(mismatch[gi]), 32'(e.mis));
               end
            end
            if (!eb && din_valid[gi]) begin
               acc      = cyc;
               active   = 1;
               last_nib = din[gi];
               for (int k = 0; k < 4; k++) begin
                  e.b    = stuck[gi] ? 1'b1 : din[gi][3 - k];
                  e.last = (k == 3);
                  e.mis  = stuck[gi] && (din[gi] != 4'hF);
                  q.push_back(e);
               end
            end
         end
      end

      task automatic send(input logic [3:0] nib);
         @(posedge clk); #1;
         din[gi]       = nib;
         din_valid[gi] = 1'b1;
         @(posedge clk); #1;
         din_valid[gi] = 1'b0;
      endtask

      task automatic idle_wait();
         repeat (F + 2) @(posedge clk);
      endtask

      initial begin
         rst_n[gi]     = 1'b0;
         din_valid[gi] = 1'b0;
         din[gi]       = 4'd0;
         stuck[gi]     = 1'b0;
         done[gi]      = 1'b0;
         repeat (2) @(posedge clk);
         #3;
         check({PFX, "rst_load"}, 32'(load[gi]), 32'd0);
         check({PFX, "rst_shift"}, 32'(shift[gi]), 32'd0);
         check({PFX, "rst_busy"}, 32'(busy[gi]), 32'd0);
         check({PFX, "rst_ready"}, 32'(din_ready[gi]), 32'd1);
         check({PFX, "rst_outs"}, 32'({tx_bit[gi], tx_strobe[gi], frame_done[gi], mismatch[gi]}), 32'd0);
         check({PFX, "rst_dout"}, 32'({d3[gi], d2[gi], d1[gi], d0[gi]}), 32'd0);
         @(posedge clk); #1;
         rst_n[gi] = 1'b1;

         send(4'b1011);
         idle_wait();

         // Back-to-back: valid held across the FRAME_DONE edge
         @(posedge clk); #1;
         din[gi]       = 4'hA;
         din_valid[gi] = 1'b1;
         @(posedge clk); #1;
         din[gi] = 4'h5;
         repeat (F) @(posedge clk);
         #1;
         din_valid[gi] = 1'b0;
         idle_wait();

         stuck[gi] = 1'b1;
         send(4'h9);
         idle_wait();
         stuck[gi] = 1'b0;
         send(4'hF);
         idle_wait();

         send(4'h6);
         idle_wait();

         // Abort during the second SHIFT_HI
         send(4'hC);
         repeat (1 + 3 * BD) @(posedge clk);
         #1;
         check({PFX, "pre_rst_shift"}, 32'(shift[gi]), 32'd1);
         #1;
         rst_n[gi] = 1'b0;
         #1;
         check({PFX, "abort_shift"}, 32'(shift[gi]), 32'd0);
         check({PFX, "abort_load"}, 32'(load[gi]), 32'd0);
         check({PFX, "abort_busy"}, 32'(busy[gi]), 32'd0);
         check({PFX, "abort_fd"}, 32'(frame_done[gi]), 32'd0);
         repeat (2) @(posedge clk);
         #1;
         rst_n[gi] = 1'b1;
         send(4'h3);
         idle_wait();

         // Valid and data churn while busy must be ignored
         send(4'h9);
         for (int j = 0; j < F - 3; j++) begin
            din[gi]       = 4'($urandom_range(0, 15));
            din_valid[gi] = j[0];
            @(posedge clk); #1;
         end
         din_valid[gi] = 1'b0;
         idle_wait();

         check({PFX, "q_empty"}, 32'(q.size()), 32'd0);
         done[gi] = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk);
         if (done == 2'b11) break;
      end
      if (done != 2'b11) check("timeout", 32'(done), 32'd3);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
